// File: rtl/aes_pkg.sv
// Shared AES constants: forward S-box, key-schedule round constants,
// AES-128 round count and the key-expansion state encoding.
package aes_pkg;

  localparam int AES128_ROUNDS = 10;

  typedef enum logic {
    IDLE,
    EXPAND
  } expandState_e;

  // RCON[i] is the round constant for round key i+1.
  localparam logic [0:9][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sboxLookup(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward byte substitution; shared with SubBytes.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data,
  output logic [7:0] subst
);

  assign subst = sboxLookup(data);

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: emits round keys 0..NR one per accepted
// valid/ready handshake, deriving each from the single held key register.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NR = AES128_ROUNDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] round_key,
  output logic [3:0]   rk_round,
  output logic         busy,
  output logic         done
);

  expandState_e stateReg, stateNext;
  logic [127:0] keyReg, keyNext;
  logic [3:0]   roundReg, roundNext;
  logic         doneReg, doneNext;

  logic [31:0]  rotWord, subWord, tempWord;
  logic [31:0]  w0Next, w1Next, w2Next, w3Next;
  logic [7:0]   rconByte;
  logic         lastRound;

  assign lastRound = (roundReg == 4'(NR));
  assign rotWord   = {keyReg[23:0], keyReg[31:24]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    aes_sbox u_sbox (
      .data  (rotWord[8*gi +: 8]),
      .subst (subWord[8*gi +: 8])
    );
  end

  // Round 10 never expands further, so its constant is unused.
  always_comb begin
    rconByte = 8'h00;
    if (roundReg < 4'(NR)) rconByte = RCON[roundReg];
  end

  assign tempWord = subWord ^ {rconByte, 24'h000000};
  assign w0Next   = keyReg[127:96] ^ tempWord;
  assign w1Next   = keyReg[95:64]  ^ w0Next;
  assign w2Next   = keyReg[63:32]  ^ w1Next;
  assign w3Next   = keyReg[31:0]   ^ w2Next;

  always_comb begin
    stateNext = stateReg;
    keyNext   = keyReg;
    roundNext = roundReg;
    doneNext  = 1'b0;
    case (stateReg)
      IDLE: begin
        if (start) begin
          stateNext = EXPAND;
          keyNext   = key_in;
          roundNext = 4'd0;
        end
      end
      EXPAND: begin
        if (rk_ready) begin
          if (lastRound) begin
            stateNext = IDLE;
            doneNext  = 1'b1;
          end else begin
            keyNext   = {w0Next, w1Next, w2Next, w3Next};
            roundNext = roundReg + 4'd1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg <= IDLE;
      keyReg   <= '0;
      roundReg <= '0;
      doneReg  <= 1'b0;
    end else begin
      stateReg <= stateNext;
      keyReg   <= keyNext;
      roundReg <= roundNext;
      doneReg  <= doneNext;
    end
  end

  assign busy      = (stateReg == EXPAND);
  assign rk_valid  = busy;
  assign round_key = keyReg;
  assign rk_round  = roundReg;
  assign done      = doneReg;

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: FIPS-197 schedule table, backpressure,
// ignored start, back-to-back restart and mid-run reset.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst, start, rk_ready, rk_valid, busy, done;
  logic [127:0] key_in, round_key;
  logic [3:0]   rk_round;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]   round;
    logic [127:0] key;
  } rkVec_t;

  rkVec_t fips[11];

  localparam logic [127:0] KEY_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_B10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] KEY_X   = 128'hdeadbeef0123456789abcdeffedcba98;

  aes_key_expand dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .round_key (round_key),
    .rk_round  (rk_round),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks the presented key against round r of the FIPS table.
  task automatic chkFips(input string tag, input int r);
    chk({tag, " valid"}, 128'(rk_valid), 128'(1));
    chk({tag, " round"}, 128'(rk_round), 128'(fips[r].round));
    chk({tag, " key"}, round_key, fips[r].key);
    chk({tag, " done"}, 128'(done), 128'(0));
    $display("%s: round %0d key %h", tag, rk_round, round_key);
  endtask

  task automatic startKey(input logic [127:0] k);
    start  = 1'b1;
    key_in = k;
    step();
    start  = 1'b0;
  endtask

  initial begin
    fips[0]  = '{4'd0,  KEY_A};
    fips[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    fips[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    fips[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    fips[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
    fips[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    fips[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    fips[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    fips[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
    fips[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
    fips[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

    rst = 1'b1; start = 1'b0; rk_ready = 1'b0; key_in = '0;
    step();
    step();
    chk("reset rk_valid", 128'(rk_valid), 128'(0));
    chk("reset busy", 128'(busy), 128'(0));
    chk("reset done", 128'(done), 128'(0));
    chk("reset rk_round", 128'(rk_round), 128'(0));
    chk("reset round_key", round_key, 128'h0);
    rst = 1'b0;

    // Idle: ready toggling must not produce a valid key
    for (int i = 0; i < 4; i++) begin
      rk_ready = i[0];
      step();
      chk("idle rk_valid", 128'(rk_valid), 128'(0));
    end

    // FIPS-197 A.1, ready held high
    rk_ready = 1'b1;
    startKey(KEY_A);
    for (int k = 0; k <= 10; k++) begin
      chkFips("fips", k);
      step();
    end
    chk("fips done pulse", 128'(done), 128'(1));
    chk("fips busy at done", 128'(busy), 128'(0));
    chk("fips valid at done", 128'(rk_valid), 128'(0));
    chk("fips held key", round_key, fips[10].key);
    chk("fips held round", 128'(rk_round), 128'(10));
    step();
    chk("fips done single", 128'(done), 128'(0));

    // Backpressure at round 3
    startKey(KEY_A);
    for (int k = 0; k <= 2; k++) begin
      chkFips("bp", k);
      step();
    end
    chkFips("bp", 3);
    rk_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chkFips("bp stall", 3);
    end
    rk_ready = 1'b1;
    step();
    for (int k = 4; k <= 10; k++) begin
      chkFips("bp", k);
      step();
    end
    chk("bp done pulse", 128'(done), 128'(1));

    // Back-to-back: start in the done cycle
    start  = 1'b1;
    key_in = KEY_B;
    step();
    start  = 1'b0;
    chk("b2b valid", 128'(rk_valid), 128'(1));
    chk("b2b busy", 128'(busy), 128'(1));
    chk("b2b round", 128'(rk_round), 128'(0));
    chk("b2b key", round_key, KEY_B);
    chk("b2b done", 128'(done), 128'(0));
    $display("b2b: round %0d key %h", rk_round, round_key);

    // Ignored start during round 5
    for (int k = 0; k <= 10; k++) begin
      chk("ign round", 128'(rk_round), 128'(k));
      chk("ign valid", 128'(rk_valid), 128'(1));
      chk("ign done", 128'(done), 128'(0));
      if (k == 5) begin
        start  = 1'b1;
        key_in = KEY_X;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    step();
    $display("ign: done=%0d", done);
    step();
    step();
    // round 10 is still held after the run
    chk("ign round10 key", round_key, KEY_B10);
    chk("ign done gone", 128'(done), 128'(0));
    chk("ign idle", 128'(busy), 128'(0));

    // done count over a full run
    begin
      int doneCount = 0;
      startKey(KEY_B);
      for (int i = 0; i < 16; i++) begin
        if (done) doneCount++;
        step();
      end
      chk("done count", 128'(doneCount), 128'(1));
      $display("dcount: done pulses %0d", doneCount);
    end

    // Reset during round 7
    startKey(KEY_A);
    for (int k = 0; k <= 6; k++) begin
      chkFips("rst", k);
      step();
    end
    chkFips("rst", 7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid rst valid", 128'(rk_valid), 128'(0));
    chk("mid rst busy", 128'(busy), 128'(0));
    chk("mid rst key", round_key, 128'h0);
    chk("mid rst round", 128'(rk_round), 128'(0));
    chk("mid rst done", 128'(done), 128'(0));
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post rst done", 128'(done), 128'(0));
      chk("post rst valid", 128'(rk_valid), 128'(0));
    end
    $display("rst: aborted at round 7");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

Iterative AES-128 key schedule for the encryption datapath. It produces the 11 round keys one at a time, in order (round 0 … round 10), over a valid/ready handshake. The AddRoundKey stage that follows MixColumns consumes these keys. One round key is derived per accepted handshake from the previous key, so only one 128-bit key register is held.

## Interface
Parameters:
- NR, 10, number of rounds; round keys 0..NR are emitted (fixed at 10 for AES-128; other values unsupported)

Ports:
- clk  in  1  rising-edge clock; the block's only clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin expansion; honoured only when busy==0
- key_in  in  128  cipher key, sampled on an accepted start; byte 0 = key_in[127:120]
- rk_valid  out  1  round_key/rk_round hold a valid round key
- rk_ready  in  1  consumer accepts the current key when rk_valid && rk_ready
- round_key  out  128  current round key; word w0 = [127:96], w3 = [31:0]
- rk_round  out  4  index of round_key, 0..10
- busy  out  1  expansion in progress
- done  out  1  one-cycle pulse after round key 10 is accepted

## Operation
- States:
  - IDLE: busy=0, rk_valid=0.
  - EXPAND: busy=1, rk_valid=1.
- IDLE → EXPAND on start:
  - key register ← key_in; rk_round ← 0.
  - Round key 0 equals the cipher key.
- EXPAND, on handshake with rk_round < 10:
  - key register ← next(key); rk_round += 1.
- EXPAND, on handshake with rk_round == 10:
  - → IDLE; done=1 for one cycle; key register and rk_round hold their last values.
- next(key):
  - t = SubWord(RotWord(w3)) ^ {Rcon[r+1], 24'h0}, where r = current rk_round.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
- RotWord: bytes {a,b,c,d} → {b,c,d,a}.
- SubWord: AES forward S-box applied to each byte. Four S-box instances, used combinationally.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36. Derive it by GF(2^8) doubling or from a constant table; both are acceptable.
- start while busy==1 is ignored; key_in is not sampled.
- No backpressure loss: while rk_valid && !rk_ready, round_key and rk_round are held stable.
- All arithmetic is XOR over bytes. The round counter never exceeds 10.

## Timing
- Reset values at the edge where rst=1: state=IDLE, busy=0, rk_valid=0, done=0, rk_round=0, round_key=128'h0.
- Reset during EXPAND aborts the expansion. No done pulse is produced.
- Accepted start at edge t → rk_valid=1 with round 0 from edge t+1.
- Handshake at edge t → next round key visible from edge t+1 (latency 1, one key per cycle).
- With rk_ready held high: start at t, round k presented during cycle t+1+k, done high during cycle t+12, busy low from t+12.
- done cycle: busy=0, so a start asserted in that same cycle is accepted. Round 0 of the new key then appears on the next cycle.
- rst has priority over start and over any handshake.

## Structure
- Shared package aes_pkg holds:
  - the S-box function or constant;
  - the Rcon constant (10×8);
  - the AES-128 round count constant (10);
  - state encoding (IDLE, EXPAND).
- Sub-module aes_sbox: 8-bit combinational byte substitution, instantiated 4× here. It is reused by SubBytes elsewhere in the datapath.
- Top-level contents: FSM, 4-bit round counter, 128-bit key register, next-key logic.

## Test plan
- FIPS-197 A.1 sequence:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1.
  - Required: round 0 equals the key; round 1 a0fafe1788542cb123a339392a6c7605; round 2 f2c295f27a96b9435935807a7359f67f; round 10 d014f9a8c9ee2589e13f0cc8b6630ca6; done during cycle t+12.
- Backpressure:
  - Stimulus: same key; rk_ready low for 5 cycles after round 3 is presented.
  - Required: round_key and rk_round frozen at round 3 with rk_valid=1; resumes with round 4 on the cycle after rk_ready rises.
- Ignored start:
  - Stimulus: start with key 000102…0f; assert start with a different key during round 5.
  - Required: the sequence is unaffected; round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- Back-to-back:
  - Stimulus: assert start with a new key in the done cycle.
  - Required: round 0 of the new key is presented on the next cycle; busy=1.
- Reset mid-operation:
  - Stimulus: rst=1 during round 7.
  - Required: next cycle rk_valid=0, busy=0, round_key=0, rk_round=0, no done pulse.
- Idle checks:
  - With no start, rk_valid stays 0 regardless of rk_ready.
  - done never asserts twice for one start.
